ddr_serializer: RTL and testbench
=================================

Name: ddr_serializer

Overview:
Parametrised successor to the fixed 48-bit/8-bit DDR mux. It pulls WORD_W-bit sample words from a show-ahead FIFO and emits them MSB-first as LANE_W-bit half-beats on both clock phases toward the host interface. Unlike the fixed version, it adds:
- FIFO-empty handshake
- run/stop control
- idle-pattern fill on underrun
- a valid/start-of-word strobe pair
- a saturating underrun counter

It sits between the IQ sample FIFO and the DDR pin driver.

Parameters:
WORD_W, 48, input word width; must be a nonzero multiple of 2*LANE_W
LANE_W, 8, DDR output lane width (bits per clock phase)
IDLE_PAT, 0, LANE_W-bit value driven on both phases when no word is being sent
CNT_W, 16, width of the underrun counter

Ports:
clk  in  1  single clock; DDR output changes on both phases of this clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run control, sampled on rising clk
fifo_empty  in  1  FIFO has no word; in_data is invalid while high
in_data  in  WORD_W  show-ahead FIFO head word
rd_req  out  1  FIFO pop; combinational; head word is consumed at the rising edge where rd_req=1
out_data  out  LANE_W  DDR data: hi half-beat while clk=1, lo half-beat while clk=0
out_valid  out  1  current beat carries word data
out_sof  out  1  current beat is slot 0 of a word
underrun_cnt  out  CNT_W  saturating count of missed word slots

Behaviour:
- Derived constant: SLOTS = WORD_W/(2*LANE_W); for the defaults, 3 beats per word. All registers update on the rising edge of clk.
- Reset (async, immediate):
  - state=IDLE, slot=0, shift register=0
  - out regs hi=lo=IDLE_PAT
  - out_valid=0, out_sof=0, underrun_cnt=0
  - rd_req is forced 0 while reset=1
  - A partially sent word is discarded, never resumed.
- States:
  - IDLE: no word in flight.
  - SEND: word in flight, slot counts 0..SLOTS-1.
- load_ok = enable & !fifo_empty & (state==IDLE | slot==SLOTS-1); rd_req = load_ok.
- On a load edge:
  - Out regs take the top 2*LANE_W bits of in_data (hi = upper LANE_W bits, lo = next LANE_W bits).
  - The remaining bits go to the shift register.
  - slot←0, state←SEND, out_valid←1, out_sof←1.
- SEND with slot<SLOTS-1:
  - Out regs take the next 2*LANE_W bits of the shift register; the shift register shifts left by 2*LANE_W.
  - slot←slot+1, out_valid←1, out_sof←0.
- At slot==SLOTS-1 (last beat being driven):
  - If load_ok: next word is loaded back-to-back with no gap beat.
  - Otherwise: state←IDLE, and out regs take IDLE_PAT on both halves with out_valid←0, out_sof←0.
- Underrun: on every rising edge where enable=1, fifo_empty=1 and (state==IDLE | slot==SLOTS-1), underrun_cnt increments, saturating at all-ones. No count while enable=0.
- enable deasserted mid-word: the current word finishes all SLOTS beats, then the block idles; no truncation.
- Latency: a word popped at edge E drives slot 0 hi during the clk-high phase after E, and slot 0 lo during the following low phase. Slot k appears k cycles after E.
- Output mux: out_data = clk ? hi_reg : lo_reg. This is the only clock-level combinational path. out_valid and out_sof are full-cycle signals aligned to the hi/lo pair.
- Throughput: one pop every SLOTS cycles at most; at most one pop per cycle. rd_req never asserts when fifo_empty=1.

Decomposition:
- Package ddr_ser_pkg holds:
  - state enum {IDLE, SEND}
  - function slots(WORD_W, LANE_W)
  - an elaboration-time check that WORD_W % (2*LANE_W) == 0
- Sub-module ddr_out_cell (parameter LANE_W):
  - holds the hi/lo registers with async reset to IDLE_PAT
  - holds the clk-level output mux
  - is reused by future multi-lane variants

Test Plan:
1. Defaults; FIFO holds 0x112233445566 and 0xAABBCCDDEEFF; enable=1.
   - out_data sequence is 11,22,33,44,55,66,AA,BB,CC,DD,EE,FF, then 00 idle.
   - rd_req pulses exactly at cycles 0 and 3.
   - out_sof high on beats 0 and 3; out_valid high for 6 cycles.
2. FIFO empty for 5 cycles with enable=1, then one word arrives.
   - underrun_cnt=5; out_data=IDLE_PAT with out_valid=0 during the wait.
   - The word then appears with rd_req one cycle.
3. enable dropped during slot 1 of a word, with the FIFO non-empty.
   - Slots 1 and 2 still complete; no further rd_req.
   - underrun_cnt unchanged while enable=0.
4. Reset asserted mid-clock during slot 1.
   - Outputs are IDLE_PAT/0 immediately, before the next edge; rd_req=0.
   - After release, the next FIFO word starts at slot 0.
5. Parameters WORD_W=32, LANE_W=16, CNT_W=2; 6 underrun slots.
   - SLOTS=1, so rd_req is high every cycle while data is present.
   - underrun_cnt saturates at 3.

Source files
------------

// File: rtl/ddr_ser_pkg.sv
// Shared types and geometry helpers for the DDR word serializer.
package ddr_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Beats (full clock cycles) needed to send one word.
  function automatic int unsigned slots(input int unsigned word_w, input int unsigned lane_w);
    return word_w / (2 * lane_w);
  endfunction

  // A word must split into a whole number of hi/lo beat pairs.
  function automatic bit geometry_ok(input int unsigned word_w, input int unsigned lane_w);
    return (lane_w != 0) && (word_w != 0) && ((word_w % (2 * lane_w)) == 0);
  endfunction

endpackage

// File: rtl/ddr_serializer_if.sv
// FIFO-side and pin-side signal bundle of the DDR word serializer.
interface ddr_serializer_if #(
  parameter int unsigned WORD_W = 48,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              enable;
  logic              fifo_empty;
  logic [WORD_W-1:0] in_data;
  logic              rd_req;
  logic [LANE_W-1:0] out_data;
  logic              out_valid;
  logic              out_sof;
  logic [CNT_W-1:0]  underrun_cnt;

  modport master (
    input  enable, fifo_empty, in_data,
    output rd_req, out_data, out_valid, out_sof, underrun_cnt
  );

  modport slave (
    output enable, fifo_empty, in_data,
    input  rd_req, out_data, out_valid, out_sof, underrun_cnt
  );
endinterface

// File: rtl/ddr_out_cell.sv
// One DDR lane: hi/lo half-beat registers plus the clock-phase output mux.
module ddr_out_cell #(
  parameter int unsigned        LANE_W   = 8,
  parameter logic [LANE_W-1:0]  IDLE_PAT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_W-1:0] hi_d,
  input  logic [LANE_W-1:0] lo_d,
  output logic [LANE_W-1:0] out_data
);
  logic [LANE_W-1:0] hi_q;
  logic [LANE_W-1:0] lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= IDLE_PAT;
      lo_q <= IDLE_PAT;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // hi half-beat while clk is high, lo half-beat while clk is low.
  assign out_data = clk ? hi_q : lo_q;
endmodule

// File: rtl/ddr_serializer.sv
// Pulls words from a show-ahead FIFO and emits them MSB-first as DDR half-beats.
module ddr_serializer
  import ddr_ser_pkg::*;
#(
  parameter int unsigned       WORD_W   = 48,
  parameter int unsigned       LANE_W   = 8,
  parameter logic [LANE_W-1:0] IDLE_PAT = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  ddr_serializer_if.master bus
);
  localparam int unsigned SLOTS  = slots(WORD_W, LANE_W);
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned BEAT_W = 2 * LANE_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  if (!geometry_ok(WORD_W, LANE_W)) begin : g_bad_geometry
    $error("ddr_serializer: WORD_W must be a nonzero multiple of 2*LANE_W");
  end

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] hi_d, lo_d;
  logic              slot_free;
  logic              load_ok;

  // A new word may start only when nothing is in flight or the last beat is going out.
  assign slot_free  = (state_q == IDLE) || (slot_q == LAST_SLOT);
  assign load_ok    = bus.enable && !bus.fifo_empty && slot_free;
  assign bus.rd_req = load_ok && !reset;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    hi_d    = IDLE_PAT;
    lo_d    = IDLE_PAT;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    cnt_d   = cnt_q;

    if (load_ok) begin
      hi_d    = bus.in_data[WORD_W-1 -: LANE_W];
      lo_d    = bus.in_data[WORD_W-LANE_W-1 -: LANE_W];
      shift_d = bus.in_data << BEAT_W;
      slot_d  = '0;
      state_d = SEND;
      valid_d = 1'b1;
      sof_d   = 1'b1;
    end else if (state_q == SEND && slot_q != LAST_SLOT) begin
      hi_d    = shift_q[WORD_W-1 -: LANE_W];
      lo_d    = shift_q[WORD_W-LANE_W-1 -: LANE_W];
      shift_d = shift_q << BEAT_W;
      slot_d  = slot_q + SLOT_W'(1);
      valid_d = 1'b1;
    end else begin
      state_d = IDLE;
      slot_d  = '0;
    end

    // Every word slot missed while running counts once, saturating.
    if (bus.enable && bus.fifo_empty && slot_free && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      cnt_q   <= cnt_d;
    end
  end

  ddr_out_cell #(
    .LANE_W   (LANE_W),
    .IDLE_PAT (IDLE_PAT)
  ) u_out_cell (
    .clk      (clk),
    .reset    (reset),
    .hi_d     (hi_d),
    .lo_d     (lo_d),
    .out_data (bus.out_data)
  );

  assign bus.out_valid    = valid_q;
  assign bus.out_sof      = sof_q;
  assign bus.underrun_cnt = cnt_q;
endmodule

// File: tb/tb_ddr_serializer.sv
// Directed bench for ddr_serializer: default 48/8 instance and a 32/16 single-slot instance.
module tb_ddr_serializer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ddr_serializer_if #(.WORD_W(48), .LANE_W(8),  .CNT_W(16)) b1 ();
  ddr_serializer_if #(.WORD_W(32), .LANE_W(16), .CNT_W(2))  b2 ();

  ddr_serializer #(.WORD_W(48), .LANE_W(8), .IDLE_PAT(8'h00), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  ddr_serializer #(.WORD_W(32), .LANE_W(16), .IDLE_PAT(16'h0000), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  int          passed = 0;
  int          total  = 0;
  logic [47:0] q1[$];
  logic [31:0] q2[$];
  bit          en1 = 1'b0;
  bit          en2 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock of dut1: drive from the FIFO model, check rd_req, then hi and lo phases.
  task automatic tick1(input string tag, input bit e_rd, input logic [7:0] e_hi,
                       input logic [7:0] e_lo, input bit e_v, input bit e_sof,
                       input logic [15:0] e_cnt);
    bit rd;
    b1.enable     = en1;
    b1.fifo_empty = (q1.size() == 0);
    b1.in_data    = (q1.size() != 0) ? q1[0] : 48'h0;
    #1;
    chk({tag, " rd_req"}, 64'(b1.rd_req), 64'(e_rd));
    rd = b1.rd_req;
    @(posedge clk);
    #1;
    if (rd && q1.size() != 0) q1.delete(0);
    #1;
    chk({tag, " hi"},    64'(b1.out_data),     64'(e_hi));
    chk({tag, " valid"}, 64'(b1.out_valid),    64'(e_v));
    chk({tag, " sof"},   64'(b1.out_sof),      64'(e_sof));
    chk({tag, " cnt"},   64'(b1.underrun_cnt), 64'(e_cnt));
    @(negedge clk);
    #1;
    chk({tag, " lo"},    64'(b1.out_data),     64'(e_lo));
  endtask

  task automatic tick2(input string tag, input bit e_rd, input logic [15:0] e_hi,
                       input logic [15:0] e_lo, input bit e_v, input bit e_sof,
                       input logic [1:0] e_cnt);
    bit rd;
    b2.enable     = en2;
    b2.fifo_empty = (q2.size() == 0);
    b2.in_data    = (q2.size() != 0) ? q2[0] : 32'h0;
    #1;
    chk({tag, " rd_req"}, 64'(b2.rd_req), 64'(e_rd));
    rd = b2.rd_req;
    @(posedge clk);
    #1;
    if (rd && q2.size() != 0) q2.delete(0);
    #1;
    chk({tag, " hi"},    64'(b2.out_data),     64'(e_hi));
    chk({tag, " valid"}, 64'(b2.out_valid),    64'(e_v));
    chk({tag, " sof"},   64'(b2.out_sof),      64'(e_sof));
    chk({tag, " cnt"},   64'(b2.underrun_cnt), 64'(e_cnt));
    @(negedge clk);
    #1;
    chk({tag, " lo"},    64'(b2.out_data),     64'(e_lo));
  endtask

  initial begin
    reset         = 1'b1;
    b2.enable     = 1'b0;
    b2.fifo_empty = 1'b1;
    b2.in_data    = 32'h0;

    // Reset state, with a word presented so rd_req suppression is visible.
    q1.push_back(48'h112233445566);
    q1.push_back(48'hAABBCCDDEEFF);
    b1.enable     = 1'b1;
    b1.fifo_empty = 1'b0;
    b1.in_data    = q1[0];
    #12;
    chk("reset out_data", 64'(b1.out_data),     64'h0);
    chk("reset valid",    64'(b1.out_valid),    64'h0);
    chk("reset sof",      64'(b1.out_sof),      64'h0);
    chk("reset cnt",      64'(b1.underrun_cnt), 64'h0);
    chk("reset rd_req",   64'(b1.rd_req),       64'h0);
    reset = 1'b0;

    // Two back-to-back words, then one underrun slot.
    en1 = 1'b1;
    tick1("t1 b0",   1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 16'd0);
    tick1("t1 b1",   1'b0, 8'h33, 8'h44, 1'b1, 1'b0, 16'd0);
    tick1("t1 b2",   1'b0, 8'h55, 8'h66, 1'b1, 1'b0, 16'd0);
    tick1("t1 b3",   1'b1, 8'hAA, 8'hBB, 1'b1, 1'b1, 16'd0);
    tick1("t1 b4",   1'b0, 8'hCC, 8'hDD, 1'b1, 1'b0, 16'd0);
    tick1("t1 b5",   1'b0, 8'hEE, 8'hFF, 1'b1, 1'b0, 16'd0);
    tick1("t1 idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd1);
    en1 = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Five empty slots while running, then a word arrives.
    en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick1("t2 empty", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'(i + 1));
    end
    q1.push_back(48'h010203040506);
    tick1("t2 s0", 1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 16'd5);
    tick1("t2 s1", 1'b0, 8'h03, 8'h04, 1'b1, 1'b0, 16'd5);
    tick1("t2 s2", 1'b0, 8'h05, 8'h06, 1'b1, 1'b0, 16'd5);
    en1 = 1'b0;
    tick1("t2 off", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd5);

    // Enable dropped after slot 0: word completes, nothing more popped or counted.
    q1.push_back(48'h102030405060);
    q1.push_back(48'h708090A0B0C0);
    en1 = 1'b1;
    tick1("t3 s0", 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 16'd5);
    en1 = 1'b0;
    tick1("t3 s1",   1'b0, 8'h30, 8'h40, 1'b1, 1'b0, 16'd5);
    tick1("t3 s2",   1'b0, 8'h50, 8'h60, 1'b1, 1'b0, 16'd5);
    tick1("t3 idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd5);
    tick1("t3 hold", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd5);

    // Reset in the high phase of slot 1; the next word restarts at slot 0.
    en1 = 1'b1;
    tick1("t4 s0", 1'b1, 8'h70, 8'h80, 1'b1, 1'b1, 16'd5);
    q1.push_back(48'hC1C2C3C4C5C6);
    b1.enable     = 1'b1;
    b1.fifo_empty = 1'b0;
    b1.in_data    = q1[0];
    #1;
    chk("t4 s1 rd_req", 64'(b1.rd_req), 64'h0);
    @(posedge clk);
    #2;
    chk("t4 s1 hi", 64'(b1.out_data), 64'h90);
    reset = 1'b1;
    #1;
    chk("t4 rst out_data", 64'(b1.out_data),     64'h0);
    chk("t4 rst valid",    64'(b1.out_valid),    64'h0);
    chk("t4 rst sof",      64'(b1.out_sof),      64'h0);
    chk("t4 rst cnt",      64'(b1.underrun_cnt), 64'h0);
    chk("t4 rst rd_req",   64'(b1.rd_req),       64'h0);
    @(negedge clk);
    #1;
    chk("t4 rst lo", 64'(b1.out_data), 64'h0);
    reset = 1'b0;
    tick1("t4 r0", 1'b1, 8'hC1, 8'hC2, 1'b1, 1'b1, 16'd0);
    tick1("t4 r1", 1'b0, 8'hC3, 8'hC4, 1'b1, 1'b0, 16'd0);
    tick1("t4 r2", 1'b0, 8'hC5, 8'hC6, 1'b1, 1'b0, 16'd0);
    en1 = 1'b0;
    tick1("t4 idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);

    // Single-slot geometry: pop every cycle, then the 2-bit counter saturates.
    b1.enable = 1'b0;
    q2.push_back(32'h11112222);
    q2.push_back(32'h33334444);
    en2 = 1'b1;
    tick2("t5 w0", 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1, 2'd0);
    tick2("t5 w1", 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      tick2("t5 empty", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
